lector_banco_registro: RTL
==========================

# lector_banco_registro

- Register-file block whose two read ports are registered and whose output uses a valid/ready handshake; this is the read side of the team's `w_r`/`direccion`/`dato` write interface.
- It stores 32 words, accepts writes on the same interface as the existing register bank, and answers paired read requests.
- Each read returns both operands one cycle after acceptance and holds them stable until the consumer takes them.
- It sits between the write-back stage and the operand-fetch consumer.

## Interface
Parameters:
- ANCHO, 32, data word width in bits
- DIR, 5, address width; depth is 2^DIR words

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- w_r  input  1  0 = write `dato` to `direccion` at this edge; 1 = no write
- direccion  input  DIR  write address
- dato  input  ANCHO  write data
- lec_valido  input  1  read request valid
- lec_listo  output  1  block can accept a read request this cycle
- dato_1  input  DIR  read address, port 1
- dato_2  input  DIR  read address, port 2
- salida_1  output  ANCHO  read data, port 1
- salida_2  output  ANCHO  read data, port 2
- salida_valida  output  1  `salida_1`/`salida_2` hold a valid result
- salida_listo  input  1  consumer takes the result this cycle

## Operation
- **Storage:** 2^DIR words of ANCHO bits, all cleared to 0 by reset.
- **Address 0 is hardwired to zero.**
  - Writes to address 0 are discarded.
  - Reads of address 0 always return 0.
- **Write:** when `w_r`==0 at a rising edge and `direccion`!=0, `mem[direccion]` <= `dato`. Writes are independent of read-handshake state and are never stalled.
- **Read acceptance:** a request is accepted at an edge where `lec_valido`&&`lec_listo`. The addresses `dato_1`/`dato_2` are sampled at that edge.
- **Write-to-read forwarding:** if an accepted read address equals `direccion` in the same cycle, `w_r`==0, and the address is nonzero, that port returns `dato` (new data), not the old contents. Both ports forward independently. Both ports may read the same address.
- **Output FSM:** two states.
  - VACIO: `salida_valida`=0.
    - Accept -> LLENO.
  - LLENO: `salida_valida`=1.
    - `salida_listo`=1 and a new accept in the same cycle -> stay in LLENO with the new data.
    - `salida_listo`=1 and no accept -> VACIO.
    - `salida_listo`=0 -> stay in LLENO and hold the data.
- **lec_listo** = !`salida_valida` || `salida_listo`. It is combinational from state and `salida_listo`; there is no path from `lec_valido`.
- **Held outputs are snapshots:** a later write to an address already read does not change `salida_1`/`salida_2` while the result is held.
- `salida_1`/`salida_2` change only on an accept. In VACIO they keep their last value; the consumer ignores them.

## Timing
- **Reset values** (asynchronous assert, synchronous-clean deassert):
  - FSM = VACIO, `salida_valida`=0, `salida_1`=`salida_2`=0
  - `lec_listo`=1
  - all storage = 0
- **Read latency:** 1 cycle. A request accepted at edge N shows its data with `salida_valida`=1 after edge N.
- **Write visibility:**
  - A write at edge N is visible to a read accepted at edge N, through forwarding.
  - It is also visible to every later read.
- **Throughput:** one read per cycle while `salida_listo` stays 1.
- **Backpressure:** with `salida_listo`=0 and `salida_valida`=1, `lec_listo`=0. The request is not accepted, and the requester keeps `lec_valido` and the addresses stable.
- **Reset mid-operation:**
  - A held result is dropped and `salida_valida` goes to 0 immediately.
  - Stored data is lost.
  - A write coinciding with reset assertion has no effect.
- No combinational path from `dato_1`/`dato_2` to the outputs; both data outputs come straight from flops.

## Test plan
1. **Reset:** assert rst_n=0 mid-stream -> `salida_valida`=0 and `salida_1`=`salida_2`=0 immediately. After release, reading addresses 5 and 31 returns 0 and 0.
2. **Write then read:** write 0xDEADBEEF to address 7 at edge N. Request (7, 0) at edge N+1 -> after N+1, `salida_1`=0xDEADBEEF, `salida_2`=0, `salida_valida`=1.
3. **Forwarding:** at one edge write 0x12345678 to address 9 while accepting a read of (9, 9) -> both outputs are 0x12345678 one cycle later. Writing 0xFFFFFFFF to address 0 while reading (0, 0) -> both outputs are 0.
4. **Backpressure:**
   - Read (3, 4) holding 0x33 and 0x44.
   - Hold `salida_listo`=0 for 3 cycles while writing 0x99 to address 3 -> outputs stay 0x33/0x44 and `lec_listo`=0.
   - Raise `salida_listo` -> the next read of 3 returns 0x99.
5. **Streaming:** `salida_listo`=1 and back-to-back requests for addresses 1..8 (preloaded with value = 0x10·address) -> 8 results on 8 consecutive cycles, in order, with no bubbles. `salida_valida` drops the cycle after the last request.

Source files
------------

// File: rtl/lector_banco_registro.sv
// lector_banco_registro: 2^DIR x ANCHO register bank with registered paired reads.
// Read results are delivered through a valid/ready handshake and held until taken.
module lector_banco_registro #(
    parameter int ANCHO = 32,
    parameter int DIR   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             w_r,
    input  logic [DIR-1:0]   direccion,
    input  logic [ANCHO-1:0] dato,
    input  logic             lec_valido,
    output logic             lec_listo,
    input  logic [DIR-1:0]   dato_1,
    input  logic [DIR-1:0]   dato_2,
    output logic [ANCHO-1:0] salida_1,
    output logic [ANCHO-1:0] salida_2,
    output logic             salida_valida,
    input  logic             salida_listo
);

    localparam int PROF = 1 << DIR;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    estado_t estado, estado_sig;

    logic [ANCHO-1:0] mem [0:PROF-1];
    logic             escribe;
    logic             acepta;
    logic [ANCHO-1:0] lee_1;
    logic [ANCHO-1:0] lee_2;

    assign escribe = !w_r && (direccion != '0);
    assign acepta  = lec_valido && lec_listo;

    // Storage: write port, address 0 never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PROF; i++) begin
                mem[i] <= '0;
            end
        end else if (escribe) begin
            mem[direccion] <= dato;
        end
    end

    // Read muxes with same-cycle write forwarding per port
    always_comb begin
        lee_1 = mem[dato_1];
        lee_2 = mem[dato_2];
        if (escribe && (dato_1 == direccion)) begin
            lee_1 = dato;
        end
        if (escribe && (dato_2 == direccion)) begin
            lee_2 = dato;
        end
        if (dato_1 == '0) begin
            lee_1 = '0;
        end
        if (dato_2 == '0) begin
            lee_2 = '0;
        end
    end

    // Output data flops: snapshot operands only when a request is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            salida_1 <= '0;
            salida_2 <= '0;
        end else if (acepta) begin
            salida_1 <= lee_1;
            salida_2 <= lee_2;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= VACIO;
        end else begin
            estado <= estado_sig;
        end
    end

    // FSM next state: fill on accept, drain when taken without refill
    always_comb begin
        estado_sig = estado;
        unique case (estado)
            VACIO: begin
                if (acepta) begin
                    estado_sig = LLENO;
                end
            end
            LLENO: begin
                if (salida_listo && !acepta) begin
                    estado_sig = VACIO;
                end
            end
            default: estado_sig = VACIO;
        endcase
    end

    // FSM outputs: valid from state, ready from state and consumer ready
    always_comb begin
        salida_valida = (estado == LLENO);
        lec_listo     = (estado == VACIO) || salida_listo;
    end

endmodule
